reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Register scoreboard for the out-of-order core.
- Tracks which architectural registers have an in-flight producer and stamps each issued writer with a tag.
- Stalls issue on RAW hazards that the forward unit cannot cover: multi-cycle ops, loads that miss, and results not yet on any bypass path.
- Sits beside decode/issue, fed by the issue-stage decoder fields and the writeback bus.

Parameters:
- TAG_W, 4, width of producer tag; at most 2^TAG_W - 1 writes may be in flight.
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired non-busy.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- i_issue_valid  in  1  issue stage holds a valid instruction
- i_uses_rs  in  1  instruction reads rs
- i_rs_addr  in  5  rs register
- i_uses_rt  in  1  instruction reads rt
- i_rt_addr  in  5  rt register
- i_uses_rw  in  1  instruction writes rw
- i_rw_addr  in  5  destination register
- i_wb_valid  in  1  writeback bus carries a result this cycle
- i_wb_tag  in  TAG_W  tag of the writing producer
- i_wb_addr  in  5  destination of the writeback
- i_flush  in  1  mispredict/exception flush
- o_stall  out  1  issue must hold this cycle
- o_issue_tag  out  TAG_W  tag assigned to the current issuing writer
- o_inflight  out  TAG_W  count of outstanding tagged writes

Behaviour:
- Clocking: clk, rst_n; reset is asynchronous, active-low.
- Reset values:
  - all busy bits 0, all entry tags 0
  - tag counter 0, inflight count 0
  - o_stall 0, o_issue_tag 0, o_inflight 0
- State:
  - per register: busy bit and TAG_W tag
  - next-tag counter
  - inflight counter
- wb_hit(r): i_wb_valid & busy[r] & tag[r]==i_wb_tag & i_wb_addr==r & r!=0.
- Hazard on rs: i_uses_rs & busy[rs] & ~wb_hit(rs). The rt hazard is identical.
  - A same-cycle writeback resolves the hazard, because the forward unit bypasses the WB value.
- Full: inflight == 2^TAG_W - 1, and the instruction has i_uses_rw with rw != 0.
- o_stall = i_issue_valid & ~i_flush & (rs hazard | rt hazard | full). It is combinational with zero latency.
- Issue fire: i_issue_valid & ~o_stall & i_uses_rw & rw != 0.
  - next edge: busy[rw] = 1, tag[rw] = next-tag, next-tag += 1 (wraps mod 2^TAG_W), inflight += 1
  - o_issue_tag = next-tag, combinationally
- Writes to register 0 never allocate and never consume a tag.
- Writeback (i_wb_valid):
  - inflight -= 1, whether or not the entry tag matches.
  - busy[i_wb_addr] is cleared only if the tag matches. A mismatch means a younger writer already owns the register; the entry stays busy.
- Issue and writeback on the same register, same cycle: issue wins, so busy stays 1 with the new tag. Inflight nets to 0 change.
- Issue and writeback on different registers: both apply, inflight unchanged.
- Writeback arriving with inflight 0 is a protocol error: assertion fires, counter saturates at 0.
- i_flush:
  - next edge clears all busy bits and inflight to 0.
  - next-tag is retained, so stale tags never alias soon.
  - Same-cycle issue and writeback are ignored.
  - o_stall is forced 0 during flush.
- Reset mid-operation returns every state element to its reset value immediately.

Decomposition:
- mips_core_pkg gains:
  - SB_TAG_W constant
  - typedef sb_tag_t as logic [SB_TAG_W-1:0]
  - typedef sb_entry_t as struct of busy and tag
- One sub-module, sb_tag_alloc: next-tag counter plus inflight counter with full flag, inc/dec/flush inputs.
- The register table stays in the top module.

Test Plan:
- Reset, issue add r5 → tag 0; next cycle issue sub reading r5 with no wb → o_stall=1. Drive wb tag 0 addr 5 → same-cycle o_stall=0; next cycle busy[5]=0.
- Issue r3 (tag 0) then r3 again (tag 1). wb tag 0 addr 3 → r3 still busy, inflight 1. wb tag 1 → r3 clear, inflight 0.
- Issue 15 writers to distinct registers → inflight 15, 16th writer stalls. A non-writing instruction with no hazard does not stall. One wb → 16th issues with tag 15; the following writer gets tag 0 (wrap).
- Same cycle: issue r7 (tag 4) and wb of r7 old tag 3 → busy[7]=1, tag 4, inflight unchanged.
- Issue to r0 → no tag consumed, o_issue_tag unchanged next cycle, reader of r0 never stalls.
- Fill 6 writers, assert i_flush with concurrent issue and wb → all busy 0, inflight 0, next-tag 6. Deassert rst_n mid-stream → outputs zero asynchronously before the next edge.

Source files
------------

// File: rtl/mips_core_pkg.sv
// ---------------------------------------------------------------------------
// mips_core_pkg
//   Shared types for the issue-stage register scoreboard.
//   SB_TAG_W    : width of a producer tag
//   SB_NUM_REGS : number of architectural registers
//   sb_tag_t    : producer tag
//   sb_entry_t  : one scoreboard row (busy flag plus owning producer tag)
// ---------------------------------------------------------------------------
package mips_core_pkg;

  localparam int SB_TAG_W    = 4;
  localparam int SB_NUM_REGS = 32;

  typedef logic [SB_TAG_W-1:0] sb_tag_t;

  typedef struct packed {
    logic    busy;
    sb_tag_t tag;
  } sb_entry_t;

endpackage

// File: rtl/sb_tag_alloc.sv
// ---------------------------------------------------------------------------
// sb_tag_alloc
//   Producer-tag allocator for the register scoreboard. It hands out tags in
//   sequence and counts how many tagged writes are still outstanding.
//   Ports:
//     clk, rst_n : core clock, asynchronous active-low reset
//     inc        : a writer issues this cycle (consumes next_tag)
//     dec        : a writeback retires an outstanding write this cycle
//     flush      : drop every outstanding write; next_tag is kept
//     next_tag   : tag the next issuing writer receives
//     inflight   : number of outstanding tagged writes
//     full       : inflight has reached 2^TAG_W - 1
// ---------------------------------------------------------------------------
module sb_tag_alloc
  import mips_core_pkg::*;
#(
  parameter int TAG_W = SB_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [TAG_W-1:0] next_tag,
  output logic [TAG_W-1:0] inflight,
  output logic             full
);

  logic dec_eff;

  // The in-flight limit is one below the tag space, so a live tag is never
  // handed out a second time while its first owner is still outstanding.
  assign full = (inflight == {TAG_W{1'b1}});

  // A writeback with nothing outstanding is a protocol error; the counter
  // saturates at zero instead of wrapping.
  assign dec_eff = dec && (inflight != '0);

  // Flush keeps next_tag so that tags of squashed writers are not reused
  // right away and cannot alias against a late writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_tag <= '0;
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else begin
      if (inc) begin
        next_tag <= next_tag + TAG_W'(1);
      end
      case ({inc, dec_eff})
        2'b10:   inflight <= inflight + TAG_W'(1);
        2'b01:   inflight <= inflight - TAG_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  wb_with_none_inflight : assert property (
    @(posedge clk) disable iff (!rst_n)
    (dec && !flush) |-> (inflight != '0)
  );

endmodule

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//   Issue-stage register scoreboard. It tracks which architectural registers
//   have an in-flight producer, stamps each issued writer with a tag, and
//   stalls issue on RAW hazards the forwarding network cannot cover.
//   Ports:
//     clk, rst_n           : core clock, asynchronous active-low reset
//     i_issue_valid        : issue stage holds a valid instruction
//     i_uses_rs/i_rs_addr  : first source operand
//     i_uses_rt/i_rt_addr  : second source operand
//     i_uses_rw/i_rw_addr  : destination register
//     i_wb_valid           : writeback bus carries a result this cycle
//     i_wb_tag/i_wb_addr   : producer tag and destination of that result
//     i_flush              : mispredict/exception flush
//     o_stall              : issue must hold this cycle (combinational)
//     o_issue_tag          : tag given to the writer issuing this cycle
//     o_inflight           : number of outstanding tagged writes
// ---------------------------------------------------------------------------
module reg_scoreboard
  import mips_core_pkg::*;
#(
  parameter int TAG_W    = SB_TAG_W,
  parameter int NUM_REGS = SB_NUM_REGS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_issue_valid,
  input  logic             i_uses_rs,
  input  logic [4:0]       i_rs_addr,
  input  logic             i_uses_rt,
  input  logic [4:0]       i_rt_addr,
  input  logic             i_uses_rw,
  input  logic [4:0]       i_rw_addr,
  input  logic             i_wb_valid,
  input  logic [TAG_W-1:0] i_wb_tag,
  input  logic [4:0]       i_wb_addr,
  input  logic             i_flush,
  output logic             o_stall,
  output logic [TAG_W-1:0] o_issue_tag,
  output logic [TAG_W-1:0] o_inflight
);

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           sb_table [NUM_REGS];

  logic             rs_wb_hit;
  logic             rt_wb_hit;
  logic             rs_hazard;
  logic             rt_hazard;
  logic             full_block;
  logic             issue_fire;
  logic             wb_clear;
  logic             alloc_full;
  logic [TAG_W-1:0] next_tag;
  logic [TAG_W-1:0] inflight;

  // A writeback whose tag matches the current owner of a source register is
  // bypassed by the forward unit in the same cycle, so it resolves the hazard.
  // Register 0 is never busy; the explicit r!=0 terms keep that obvious.
  always_comb begin
    rs_wb_hit  = i_wb_valid && sb_table[i_rs_addr].busy &&
                 (sb_table[i_rs_addr].tag == i_wb_tag) &&
                 (i_wb_addr == i_rs_addr) && (i_rs_addr != 5'd0);
    rt_wb_hit  = i_wb_valid && sb_table[i_rt_addr].busy &&
                 (sb_table[i_rt_addr].tag == i_wb_tag) &&
                 (i_wb_addr == i_rt_addr) && (i_rt_addr != 5'd0);
    rs_hazard  = i_uses_rs && sb_table[i_rs_addr].busy && !rs_wb_hit;
    rt_hazard  = i_uses_rt && sb_table[i_rt_addr].busy && !rt_wb_hit;
    full_block = alloc_full && i_uses_rw && (i_rw_addr != 5'd0);
    o_stall    = i_issue_valid && !i_flush &&
                 (rs_hazard || rt_hazard || full_block);
  end

  // Only writers to a real register allocate a tag; a flush squashes the
  // issuing instruction even though it forces o_stall low.
  always_comb begin
    issue_fire = i_issue_valid && !i_flush && !o_stall &&
                 i_uses_rw && (i_rw_addr != 5'd0);
    wb_clear   = i_wb_valid && sb_table[i_wb_addr].busy &&
                 (sb_table[i_wb_addr].tag == i_wb_tag) &&
                 (i_wb_addr != 5'd0);
  end

  sb_tag_alloc #(
    .TAG_W (TAG_W)
  ) u_tag_alloc (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (issue_fire),
    .dec      (i_wb_valid),
    .flush    (i_flush),
    .next_tag (next_tag),
    .inflight (inflight),
    .full     (alloc_full)
  );

  // A tag mismatch on writeback means a younger writer already owns the
  // register, so the row stays busy. When issue and writeback hit the same
  // row in one cycle the issue update is written last and wins. Flush only
  // clears busy flags; stale tags in idle rows are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        sb_table[i] <= '0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        sb_table[i].busy <= 1'b0;
      end
    end else begin
      if (wb_clear) begin
        sb_table[i_wb_addr].busy <= 1'b0;
      end
      if (issue_fire) begin
        sb_table[i_rw_addr].busy <= 1'b1;
        sb_table[i_rw_addr].tag  <= next_tag;
      end
    end
  end

  assign o_issue_tag = next_tag;
  assign o_inflight  = inflight;

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//   Self-checking bench for reg_scoreboard: a directed vector table, hand
//   sequences for the full/wrap, flush and asynchronous reset corners, and a
//   randomized phase checked against a behavioural scoreboard model.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

  localparam int TAG_W    = 4;
  localparam int MAX_INFL = 15;
  localparam int NUM_TAGS = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_issue_valid;
  logic             i_uses_rs;
  logic [4:0]       i_rs_addr;
  logic             i_uses_rt;
  logic [4:0]       i_rt_addr;
  logic             i_uses_rw;
  logic [4:0]       i_rw_addr;
  logic             i_wb_valid;
  logic [TAG_W-1:0] i_wb_tag;
  logic [4:0]       i_wb_addr;
  logic             i_flush;
  logic             o_stall;
  logic [TAG_W-1:0] o_issue_tag;
  logic [TAG_W-1:0] o_inflight;

  int n_checks = 0;
  int n_errors = 0;

  int m_busy [32];
  int m_tag  [32];
  int m_next;
  int m_infl;

  typedef struct {
    logic       valid;
    logic       urs;
    logic [4:0] rs;
    logic       urt;
    logic [4:0] rt;
    logic       urw;
    logic [4:0] rw;
    logic       wbv;
    logic [3:0] wbt;
    logic [4:0] wba;
    logic       flush;
    logic       exp_stall;
    logic [3:0] exp_tag;
    logic [3:0] exp_infl;
  } vec_t;

  vec_t vecs [$];

  reg_scoreboard #(
    .TAG_W    (TAG_W),
    .NUM_REGS (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_issue_valid (i_issue_valid),
    .i_uses_rs     (i_uses_rs),
    .i_rs_addr     (i_rs_addr),
    .i_uses_rt     (i_uses_rt),
    .i_rt_addr     (i_rt_addr),
    .i_uses_rw     (i_uses_rw),
    .i_rw_addr     (i_rw_addr),
    .i_wb_valid    (i_wb_valid),
    .i_wb_tag      (i_wb_tag),
    .i_wb_addr     (i_wb_addr),
    .i_flush       (i_flush),
    .o_stall       (o_stall),
    .o_issue_tag   (o_issue_tag),
    .o_inflight    (o_inflight)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int valid, input int urs, input int rs,
                              input int urt, input int rt, input int urw,
                              input int rw, input int wbv, input int wbt,
                              input int wba, input int flush, input int stall,
                              input int tag, input int infl);
    vec_t v;
    v.valid     = (valid != 0);
    v.urs       = (urs != 0);
    v.rs        = 5'(rs);
    v.urt       = (urt != 0);
    v.rt        = 5'(rt);
    v.urw       = (urw != 0);
    v.rw        = 5'(rw);
    v.wbv       = (wbv != 0);
    v.wbt       = 4'(wbt);
    v.wba       = 5'(wba);
    v.flush     = (flush != 0);
    v.exp_stall = (stall != 0);
    v.exp_tag   = 4'(tag);
    v.exp_infl  = 4'(infl);
    return v;
  endfunction

  // Reference model: a register is "owned" by the latest issued writer; a
  // writeback frees it only when it comes from that owner.
  task automatic modelReset();
    for (int r = 0; r < 32; r++) begin
      m_busy[r] = 0;
      m_tag[r]  = 0;
    end
    m_next = 0;
    m_infl = 0;
  endtask

  function automatic bit model_hit(input int r);
    return i_wb_valid && (m_busy[r] != 0) && (m_tag[r] == int'(i_wb_tag)) &&
           (int'(i_wb_addr) == r) && (r != 0);
  endfunction

  function automatic bit model_stall();
    bit haz_rs;
    bit haz_rt;
    bit full;
    haz_rs = i_uses_rs && (m_busy[int'(i_rs_addr)] != 0) && !model_hit(int'(i_rs_addr));
    haz_rt = i_uses_rt && (m_busy[int'(i_rt_addr)] != 0) && !model_hit(int'(i_rt_addr));
    full   = (m_infl == MAX_INFL) && i_uses_rw && (i_rw_addr != 5'd0);
    return i_issue_valid && !i_flush && (haz_rs || haz_rt || full);
  endfunction

  task automatic modelTick();
    bit fire;
    bit hit;
    int wa;
    int rw;
    @(posedge clk);
    wa   = int'(i_wb_addr);
    rw   = int'(i_rw_addr);
    fire = i_issue_valid && !model_stall() && i_uses_rw && (rw != 0);
    hit  = model_hit(wa);
    if (i_flush) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 0;
      m_infl = 0;
    end else begin
      if (i_wb_valid && m_infl > 0) m_infl = m_infl - 1;
      if (fire) m_infl = m_infl + 1;
      if (hit) m_busy[wa] = 0;
      if (fire) begin
        m_busy[rw] = 1;
        m_tag[rw]  = m_next;
        m_next     = (m_next + 1) % NUM_TAGS;
      end
    end
  endtask

  task automatic clearInputs();
    i_issue_valid = 1'b0;
    i_uses_rs     = 1'b0;
    i_rs_addr     = 5'd0;
    i_uses_rt     = 1'b0;
    i_rt_addr     = 5'd0;
    i_uses_rw     = 1'b0;
    i_rw_addr     = 5'd0;
    i_wb_valid    = 1'b0;
    i_wb_tag      = 4'd0;
    i_wb_addr     = 5'd0;
    i_flush       = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    i_issue_valid = v.valid;
    i_uses_rs     = v.urs;
    i_rs_addr     = v.rs;
    i_uses_rt     = v.urt;
    i_rt_addr     = v.rt;
    i_uses_rw     = v.urw;
    i_rw_addr     = v.rw;
    i_wb_valid    = v.wbv;
    i_wb_tag      = v.wbt;
    i_wb_addr     = v.wba;
    i_flush       = v.flush;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic runVector(input string name, input vec_t v);
    applyStimulus(v);
    #1;
    checkOutput({name, ".stall"},    int'(o_stall),     int'(v.exp_stall));
    checkOutput({name, ".tag"},      int'(o_issue_tag), int'(v.exp_tag));
    checkOutput({name, ".inflight"}, int'(o_inflight),  int'(v.exp_infl));
    modelTick();
  endtask

  task automatic doReset();
    @(negedge clk);
    clearInputs();
    rst_n = 1'b0;
    #2;
    modelReset();
    rst_n = 1'b1;
  endtask

  function automatic int pickReg();
    if ($urandom_range(0, 3) != 0) return int'($urandom_range(0, 7));
    return int'($urandom_range(0, 31));
  endfunction

  task automatic randomCycle(input int idx);
    vec_t v;
    int   busy_q [$];
    int   r;
    v       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.valid = ($urandom_range(0, 3) != 0);
    v.urs   = ($urandom_range(0, 1) == 1);
    v.rs    = 5'(pickReg());
    v.urt   = ($urandom_range(0, 1) == 1);
    v.rt    = 5'(pickReg());
    v.urw   = ($urandom_range(0, 1) == 1);
    v.rw    = 5'(pickReg());
    if (m_infl > 0 && $urandom_range(0, 2) == 0) begin
      for (int k = 1; k < 32; k++) begin
        if (m_busy[k] != 0) busy_q.push_back(k);
      end
      v.wbv = 1'b1;
      if (busy_q.size() > 0 && $urandom_range(0, 7) != 0) begin
        r     = busy_q[$urandom_range(0, busy_q.size() - 1)];
        v.wba = 5'(r);
        v.wbt = 4'(m_tag[r]);
      end else begin
        v.wba = 5'($urandom_range(0, 31));
        v.wbt = 4'($urandom_range(0, 15));
      end
    end
    v.flush = ($urandom_range(0, 49) == 0);
    applyStimulus(v);
    #1;
    checkOutput($sformatf("rnd%0d.stall", idx),    int'(o_stall),     int'(model_stall()));
    checkOutput($sformatf("rnd%0d.tag", idx),      int'(o_issue_tag), m_next);
    checkOutput($sformatf("rnd%0d.inflight", idx), int'(o_inflight),  m_infl);
    modelTick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    clearInputs();
    modelReset();
    #12;
    checkOutput("reset.stall",    int'(o_stall),     0);
    checkOutput("reset.tag",      int'(o_issue_tag), 0);
    checkOutput("reset.inflight", int'(o_inflight),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // valid urs rs urt rt urw rw | wbv wbt wba | flush | stall tag infl
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 2, 1, 5,  0, 0, 0,  0,  0, 0, 0));
    vecs.push_back(mk(1, 1, 5, 0, 0, 1, 6,  0, 0, 0,  0,  1, 1, 1));
    vecs.push_back(mk(1, 1, 5, 0, 0, 1, 6,  1, 0, 5,  0,  0, 1, 1));
    vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0,  0, 0, 0,  0,  0, 2, 1));
    vecs.push_back(mk(1, 0, 0, 1, 6, 0, 0,  0, 0, 0,  0,  1, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 6,  0,  0, 2, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3,  0, 0, 0,  0,  0, 2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3,  0, 0, 0,  0,  0, 3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 2, 3,  0,  0, 4, 2));
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0,  0, 0, 0,  0,  1, 4, 1));
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0,  1, 3, 3,  0,  0, 4, 1));
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0,  0, 0, 0,  0,  0, 4, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7,  0, 0, 0,  0,  0, 4, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7,  1, 4, 7,  0,  0, 5, 1));
    vecs.push_back(mk(1, 1, 7, 0, 0, 0, 0,  0, 0, 0,  0,  1, 6, 1));
    vecs.push_back(mk(1, 1, 7, 0, 0, 0, 0,  1, 5, 7,  0,  0, 6, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0,  0, 0, 0,  0,  0, 6, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0, 6, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0,  0, 0, 0,  0,  0, 6, 0));

    foreach (vecs[i]) runVector($sformatf("vec%0d", i), vecs[i]);

    doReset();
    for (int i = 0; i < 15; i++) begin
      runVector($sformatf("fill%0d", i), mk(1, 0, 0, 0, 0, 1, i + 1, 0, 0, 0, 0, 0, i, i));
    end
    runVector("full_stall",     mk(1, 0, 0, 0, 0, 1, 16,  0, 0, 0, 0,  1, 15, 15));
    runVector("full_nonwriter", mk(1, 1, 20, 1, 21, 0, 0, 0, 0, 0, 0,  0, 15, 15));
    runVector("full_reader",    mk(1, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0,  1, 15, 15));
    runVector("full_wb_same",   mk(1, 0, 0, 0, 0, 1, 16,  1, 0, 1, 0,  1, 15, 15));
    runVector("full_issue15",   mk(1, 0, 0, 0, 0, 1, 16,  0, 0, 0, 0,  0, 15, 14));
    runVector("drain_one",      mk(0, 0, 0, 0, 0, 0, 0,   1, 1, 2, 0,  0, 0, 15));
    runVector("wrap_tag0",      mk(1, 0, 0, 0, 0, 1, 17,  0, 0, 0, 0,  0, 0, 14));
    runVector("post_wrap",      mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 15));

    applyStimulus(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("pre_rst.stall",    int'(o_stall),     1);
    checkOutput("pre_rst.tag",      int'(o_issue_tag), 1);
    checkOutput("pre_rst.inflight", int'(o_inflight),  15);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst.stall",    int'(o_stall),     0);
    checkOutput("async_rst.tag",      int'(o_issue_tag), 0);
    checkOutput("async_rst.inflight", int'(o_inflight),  0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      runVector($sformatf("ffill%0d", i), mk(1, 0, 0, 0, 0, 1, i + 1, 0, 0, 0, 0, 0, i, i));
    end
    runVector("flush_forced",   mk(1, 1, 2, 0, 0, 1, 8,  1, 0, 1, 1,  0, 6, 6));
    runVector("flush_cleared",  mk(1, 1, 2, 1, 8, 0, 0,  0, 0, 0, 0,  0, 6, 0));
    runVector("flush_reissue",  mk(1, 1, 1, 1, 6, 1, 9,  0, 0, 0, 0,  0, 6, 0));
    runVector("flush_tag_kept", mk(1, 1, 9, 0, 0, 0, 0,  0, 0, 0, 0,  1, 7, 1));
    runVector("flush_drain",    mk(0, 0, 0, 0, 0, 0, 0,  1, 6, 9, 0,  0, 7, 1));
    runVector("flush_drained",  mk(1, 1, 9, 0, 0, 0, 0,  0, 0, 0, 0,  0, 7, 0));

    for (int i = 0; i < 400; i++) randomCycle(i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
